// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS definitions.
//   - The four control-token code words, common to encoder and decoder.
//   - rx_state_t: word-alignment FSM states of the receive channel.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } rx_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational TMDS symbol classifier/decoder.
// Ports:
//   sym      in  10  raw symbol, sym[0] first on the wire
//   is_token out  1  sym is one of the four control tokens
//   ctrl     out  2  control bits {c1, c0} of the token (0 otherwise)
//   data     out  8  transition-minimized decode of sym (always computed)
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_token,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] d;

  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    case (sym)
      TOKEN_C00: ctrl = 2'b00;
      TOKEN_C01: ctrl = 2'b01;
      TOKEN_C10: ctrl = 2'b10;
      TOKEN_C11: ctrl = 2'b11;
      default:   is_token = 1'b0;
    endcase
  end

  // sym[9] flags an inverted payload; sym[8] selects XOR vs XNOR chaining.
  always_comb begin
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = 8'h00;
    data[0] = d[0];
    for (int i = 1; i < 8; i++)
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

endmodule

// File: rtl/tmds_rx_channel.sv
// tmds_rx_channel: one TMDS receive lane after the 1:10 deserializer.
// Finds the word boundary by bit-slipping until control tokens arrive
// steadily, then decodes symbols into pixel data or control bits.
// Ports:
//   clk     in   1  pixel clock, one symbol per cycle
//   rst     in   1  synchronous active-high reset
//   sym     in  10  deserialized word
//   bitslip out  1  one-cycle slip request to the deserializer
//   locked  out  1  word alignment established
//   de      out  1  data is valid pixel data
//   data    out  8  decoded byte
//   ctrl    out  2  last decoded control bits {c1, c0}
// Latency sym -> outputs is 2 cycles; the FSM runs on the stage-1 registers.
module tmds_rx_channel
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT    = 64,
  parameter int SEARCH_WINDOW = 1024,
  parameter int SLIP_WAIT     = 16,
  parameter int TIMEOUT       = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sym,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctrl
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int SW_W  = $clog2(SLIP_WAIT + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  // stage 1: classification of the incoming symbol
  logic       dec_tok;
  logic [1:0] dec_ctrl;
  logic [7:0] dec_data;
  logic       s1_tok;
  logic [1:0] s1_ctrl;
  logic [7:0] s1_data;

  tmds_symbol_decode u_dec (
    .sym      (sym),
    .is_token (dec_tok),
    .ctrl     (dec_ctrl),
    .data     (dec_data)
  );

  rx_state_t        state;
  logic [RUN_W-1:0] run;
  logic [WIN_W-1:0] win;
  logic [SW_W-1:0]  sw;
  logic [WD_W-1:0]  wd;

  // Lock is declared on the cycle the LOCK_COUNT-th token sits in stage 1,
  // so the locking token itself is already reported with locked=1.
  logic run_hit, win_end, sw_end, wd_end;
  assign run_hit = s1_tok && (run == RUN_W'(LOCK_COUNT - 1));
  assign win_end = (win == WIN_W'(SEARCH_WINDOW - 1));
  assign sw_end  = (sw  == SW_W'(SLIP_WAIT - 1));
  assign wd_end  = (wd  == WD_W'(TIMEOUT - 1));

  // stage-2 values used whenever the channel is (or becomes) locked
  logic       lk_de;
  logic [7:0] lk_data;
  logic [1:0] lk_ctrl;

  always_comb begin
    lk_de   = ~s1_tok;
    lk_data = s1_tok ? 8'h00 : s1_data;
    lk_ctrl = s1_tok ? s1_ctrl : ctrl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_tok  <= 1'b0;
      s1_ctrl <= 2'b00;
      s1_data <= 8'h00;
      state   <= ST_SEARCH;
      run     <= '0;
      win     <= '0;
      sw      <= '0;
      wd      <= '0;
      bitslip <= 1'b0;
      locked  <= 1'b0;
      de      <= 1'b0;
      data    <= 8'h00;
      ctrl    <= 2'b00;
    end else begin
      s1_tok  <= dec_tok;
      s1_ctrl <= dec_ctrl;
      s1_data <= dec_data;

      // idle outputs unless a branch below keeps/enters lock
      bitslip <= 1'b0;
      locked  <= 1'b0;
      de      <= 1'b0;
      data    <= 8'h00;
      ctrl    <= 2'b00;

      case (state)
        ST_SEARCH: begin
          if (run_hit) begin
            state  <= ST_LOCKED;
            run    <= '0;
            wd     <= '0;
            win    <= '0;
            locked <= 1'b1;
            de     <= lk_de;
            data   <= lk_data;
            ctrl   <= lk_ctrl;
          end else if (win_end) begin
            state   <= ST_SLIP_WAIT;
            bitslip <= 1'b1;
            win     <= '0;
            run     <= '0;
          end else begin
            win <= win + 1'b1;
            run <= s1_tok ? run + 1'b1 : '0;
          end
        end

        ST_SLIP_WAIT: begin
          if (sw_end) begin
            state <= ST_SEARCH;
            sw    <= '0;
          end else begin
            sw <= sw + 1'b1;
          end
        end

        ST_LOCKED: begin
          // a token arriving on the timeout cycle keeps lock
          if (!s1_tok && wd_end) begin
            state <= ST_SEARCH;
            run   <= '0;
            win   <= '0;
            sw    <= '0;
            wd    <= '0;
          end else begin
            wd     <= s1_tok ? '0 : wd + 1'b1;
            locked <= 1'b1;
            de     <= lk_de;
            data   <= lk_data;
            ctrl   <= lk_ctrl;
          end
        end

        default: state <= ST_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Self-checking bench for tmds_rx_channel: a behavioural model predicts
// every output cycle; directed sequences pin lock latency, decode values,
// timeout behaviour, reset and the bit-slip alignment search.
module tb_tmds_rx_channel;

  localparam int LOCK_COUNT    = 64;
  localparam int SEARCH_WINDOW = 1024;
  localparam int SLIP_WAIT     = 16;
  localparam int TIMEOUT       = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sym = '0;
  logic       bitslip, locked, de;
  logic [7:0] data;
  logic [1:0] ctrl;

  always #5 clk = ~clk;

  tmds_rx_channel #(
    .LOCK_COUNT    (LOCK_COUNT),
    .SEARCH_WINDOW (SEARCH_WINDOW),
    .SLIP_WAIT     (SLIP_WAIT),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sym     (sym),
    .bitslip (bitslip),
    .locked  (locked),
    .de      (de),
    .data    (data),
    .ctrl    (ctrl)
  );

  logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011,
                           10'b0101010100, 10'b1010101011};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int tok_index(input logic [9:0] w);
    for (int i = 0; i < 4; i++)
      if (w == toks[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] d, o;
    d = w[9] ? ~w[7:0] : w[7:0];
    o = '0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = d[i] ^ d[i-1] ^ ~w[8];
    return o;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom_range(1023)); while (tok_index(w) >= 0);
    return w;
  endfunction

  // serial stream seen k bit positions late
  function automatic logic [9:0] rot(input logic [9:0] w, input int k);
    logic [19:0] x;
    x = {w, w};
    x = x >> k;
    return x[9:0];
  endfunction

  // ---------------- behavioural model ----------------
  localparam int M_SEARCH = 0, M_SETTLE = 1, M_LOCK = 2;
  int         mode, streak, age, settle, quiet;
  bit         started = 0;
  bit         p_tok;
  int         p_ctl;
  logic [7:0] p_dat;
  logic       e_bitslip = 0, e_locked = 0, e_de = 0;
  logic [7:0] e_data = 0;
  logic [1:0] e_ctrl = 0;

  task automatic model_step(input bit tok, input int c, input logic [7:0] dat);
    e_bitslip = 0;
    if (mode == M_LOCK) begin
      if (tok) quiet = 0;
      else if (quiet == TIMEOUT - 1) begin
        mode = M_SEARCH; quiet = 0; streak = 0; age = 0;
      end else quiet++;
    end else if (mode == M_SETTLE) begin
      if (settle == SLIP_WAIT - 1) begin mode = M_SEARCH; settle = 0; end
      else settle++;
    end else begin
      streak = tok ? streak + 1 : 0;
      if (streak == LOCK_COUNT) begin
        mode = M_LOCK; streak = 0; quiet = 0; age = 0;
      end else if (age == SEARCH_WINDOW - 1) begin
        e_bitslip = 1; age = 0; streak = 0; mode = M_SETTLE;
      end else age++;
    end
    if (mode == M_LOCK) begin
      e_locked = 1;
      if (tok) begin e_de = 0; e_data = 0; e_ctrl = 2'(c); end
      else begin e_de = 1; e_data = dat; end
    end else begin
      e_locked = 0; e_de = 0; e_data = 0; e_ctrl = 0;
    end
  endtask

  initial begin
    int ti;
    forever begin
      @(posedge clk);
      if (rst) begin
        started = 1;
        mode = M_SEARCH; streak = 0; age = 0; settle = 0; quiet = 0;
        e_bitslip = 0; e_locked = 0; e_de = 0; e_data = 0; e_ctrl = 0;
        p_tok = 0; p_ctl = 0; p_dat = 0;
      end else begin
        model_step(p_tok, p_ctl, p_dat);
        ti    = tok_index(sym);
        p_tok = (ti >= 0);
        p_ctl = (ti >= 0) ? ti : 0;
        p_dat = ref_decode(sym);
      end
    end
  end

  // compare process: every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("bitslip", bitslip, e_bitslip);
        chk("locked",  locked,  e_locked);
        chk("de",      de,      e_de);
        chk("data",    data,    e_data);
        chk("ctrl",    ctrl,    e_ctrl);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [9:0] w);
    sym = w;
    @(negedge clk);
  endtask

  // feed C00 tokens until locked is seen; lat = cycles since first token
  task automatic lock_seq(output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (locked === 1'b1) begin lat = i; break; end
      drive(toks[0]);
    end
  endtask

  initial begin
    int lat, slips, last_slip, k, cyc;
    bit got_lock;

    rst = 1'b1;
    sym = '0;
    repeat (3) @(negedge clk);
    chk("reset_locked", locked, 1'b0);
    chk("reset_bitslip", bitslip, 1'b0);
    chk("reset_data", {de, data, ctrl}, 11'd0);
    rst = 1'b0;

    // first lock: 64 tokens, locked at the 66th cycle counting from 1
    lock_seq(lat);
    chk("lock_latency", lat, 65);
    chk("lock_de", de, 1'b0);
    chk("lock_ctrl", ctrl, 2'b00);

    // two data symbols decode to 00 and FF
    drive(10'b0100000000);
    drive(10'b1000000000);
    chk("dec00_de", de, 1'b1);
    chk("dec00_data", data, 8'h00);
    drive(toks[0]);
    chk("decFF_data", data, 8'hFF);
    chk("decFF_ctrl", ctrl, 2'b00);
    drive(toks[0]);

    // all four tokens in order
    for (int k2 = 0; k2 < 5; k2++) begin
      drive(toks[(k2 < 4) ? k2 : 3]);
      if (k2 >= 1) begin
        chk("ctrl_seq", ctrl, 32'(k2 - 1));
        chk("ctrl_seq_de", de, 1'b0);
        chk("ctrl_seq_locked", locked, 1'b1);
      end
    end

    // random mix of data and tokens while locked
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(4) == 0) ? toks[$urandom_range(3)] : rand_data());

    // timeout: 2048 data symbols after the last token
    drive(toks[0]);
    for (int i = 0; i < TIMEOUT; i++) drive(rand_data());
    chk("pre_timeout_locked", locked, 1'b1);
    drive(rand_data());
    chk("timeout_locked", locked, 1'b0);
    chk("timeout_de", de, 1'b0);

    lock_seq(lat);
    chk("relock_latency", lat, 65);

    // token on the timeout cycle keeps lock
    drive(toks[0]);
    for (int i = 0; i < TIMEOUT - 1; i++) drive(rand_data());
    drive(toks[1]);
    for (int i = 0; i < 4; i++) begin
      drive(rand_data());
      chk("token_wins_locked", locked, 1'b1);
    end
    chk("token_wins_ctrl", ctrl, 2'b01);

    // reset while streaming data
    for (int i = 0; i < 5; i++) drive(rand_data());
    rst = 1'b1;
    drive(rand_data());
    chk("rst_outputs", {bitslip, locked, de, data, ctrl}, 13'd0);
    rst = 1'b0;
    lock_seq(lat);
    chk("rst_relock_latency", lat, 65);

    // alignment search: stream rotated by 3 bits, each slip moves it by 1
    rst = 1'b1;
    drive(10'd0);
    rst = 1'b0;
    k = 3; slips = 0; last_slip = -1; got_lock = 0;
    for (cyc = 0; cyc < 12000; cyc++) begin
      if (locked === 1'b1) begin got_lock = 1; break; end
      if (bitslip === 1'b1) begin
        if (last_slip >= 0) chk("slip_period", cyc - last_slip, SEARCH_WINDOW + SLIP_WAIT);
        last_slip = cyc;
        slips++;
        k = (k + 1) % 10;
      end
      drive(rot(toks[0], k));
    end
    chk("slip_lock", got_lock, 1'b1);
    chk("slip_count", slips, 7);
    for (int i = 0; i < 300; i++)
      drive(rot(($urandom_range(5) == 0) ? toks[$urandom_range(3)] : rand_data(), k));
    chk("post_slip_locked", locked, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
